// File: rtl/spi_ram_ctrl_if.sv
// Bundle of SPI-slave, local-requester and RAM-port signals around spi_ram_ctrl.
// The controller uses the slave view; the surrounding environment uses the master view.
interface spi_ram_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 loc_req;
  logic                 loc_we;
  logic [ADDR_SIZE-1:0] loc_addr;
  logic [7:0]           loc_wdata;
  logic                 loc_gnt;
  logic                 loc_rvalid;
  logic [7:0]           loc_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;
  logic                 cmd_drop;

  modport slave (
    input  rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    output tx_data, tx_valid, loc_gnt, loc_rvalid, loc_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, cmd_drop
  );

  modport master (
    output rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    input  tx_data, tx_valid, loc_gnt, loc_rvalid, loc_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, cmd_drop
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI command frames, arbitrates one single-port RAM round-robin between
// the SPI side and a local requester, and returns read data to both sides.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    SRC_LOCAL = 1'b0,
    SRC_SPI   = 1'b1
  } src_t;

  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    if (a == ADDR_LAST) begin
      return {ADDR_SIZE{1'b0}};
    end else begin
      return a + ADDR_SIZE'(1);
    end
  endfunction

  state_t               state_r, state_n_s;
  src_t                 last_grant_r, src_r;
  logic                 rx_valid_q_r;
  logic [ADDR_SIZE-1:0] wr_addr_r, rd_addr_r;
  logic                 spi_pend_r, spi_we_r;
  logic [7:0]           spi_wdata_r;
  logic                 mem_en_r, mem_we_r;
  logic [ADDR_SIZE-1:0] mem_addr_r;
  logic [7:0]           mem_wdata_r;
  logic [7:0]           tx_data_r, loc_rdata_r;
  logic                 tx_valid_r, loc_gnt_r, loc_rvalid_r, cmd_drop_r;
  logic                 new_cmd_s, spi_win_s, loc_win_s;
  logic [1:0]           cmd_s;

  assign new_cmd_s = bus.rx_valid & ~rx_valid_q_r;
  assign cmd_s     = bus.rx_data[9:8];

  // Next state and arbitration winner; a tie goes to whoever was not granted last.
  always_comb begin
    state_n_s = state_r;
    spi_win_s = 1'b0;
    loc_win_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (spi_pend_r && bus.loc_req) begin
          if (last_grant_r == SRC_LOCAL) begin
            spi_win_s = 1'b1;
          end else begin
            loc_win_s = 1'b1;
          end
        end else if (spi_pend_r) begin
          spi_win_s = 1'b1;
        end else if (bus.loc_req) begin
          loc_win_s = 1'b1;
        end else begin
          spi_win_s = 1'b0;
        end
        if (spi_win_s || loc_win_s) begin
          state_n_s = ACCESS;
        end else begin
          state_n_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_we_r) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = RD_WAIT;
        end
      end
      RD_WAIT: state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Frame decode, RAM port drive and read-data return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q_r <= 1'b0;
      wr_addr_r    <= {ADDR_SIZE{1'b0}};
      rd_addr_r    <= {ADDR_SIZE{1'b0}};
      spi_pend_r   <= 1'b0;
      spi_we_r     <= 1'b0;
      spi_wdata_r  <= 8'h00;
      last_grant_r <= SRC_LOCAL;
      src_r        <= SRC_LOCAL;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_SIZE{1'b0}};
      mem_wdata_r  <= 8'h00;
      tx_data_r    <= 8'h00;
      tx_valid_r   <= 1'b0;
      loc_gnt_r    <= 1'b0;
      loc_rvalid_r <= 1'b0;
      loc_rdata_r  <= 8'h00;
      cmd_drop_r   <= 1'b0;
    end else begin
      rx_valid_q_r <= bus.rx_valid;
      cmd_drop_r   <= 1'b0;
      loc_gnt_r    <= 1'b0;
      loc_rvalid_r <= 1'b0;

      // Decode never collides with an SPI grant: both need opposite spi_pend values.
      if (new_cmd_s) begin
        if (spi_pend_r) begin
          cmd_drop_r <= 1'b1;
        end else begin
          case (cmd_s)
            2'b00: wr_addr_r <= bus.rx_data[ADDR_SIZE-1:0];
            2'b10: rd_addr_r <= bus.rx_data[ADDR_SIZE-1:0];
            2'b01: begin
              spi_pend_r  <= 1'b1;
              spi_we_r    <= 1'b1;
              spi_wdata_r <= bus.rx_data[7:0];
            end
            2'b11: begin
              spi_pend_r <= 1'b1;
              spi_we_r   <= 1'b0;
            end
            default: cmd_drop_r <= 1'b0;
          endcase
        end
      end

      case (state_r)
        IDLE: begin
          if (spi_win_s) begin
            mem_en_r     <= 1'b1;
            mem_we_r     <= spi_we_r;
            spi_pend_r   <= 1'b0;
            last_grant_r <= SRC_SPI;
            src_r        <= SRC_SPI;
            if (spi_we_r) begin
              mem_addr_r  <= wr_addr_r;
              mem_wdata_r <= spi_wdata_r;
              wr_addr_r   <= addr_inc(wr_addr_r);
            end else begin
              mem_addr_r  <= rd_addr_r;
              mem_wdata_r <= 8'h00;
              rd_addr_r   <= addr_inc(rd_addr_r);
            end
          end else if (loc_win_s) begin
            mem_en_r     <= 1'b1;
            mem_we_r     <= bus.loc_we;
            mem_addr_r   <= bus.loc_addr;
            mem_wdata_r  <= bus.loc_wdata;
            loc_gnt_r    <= 1'b1;
            last_grant_r <= SRC_LOCAL;
            src_r        <= SRC_LOCAL;
          end else begin
            mem_en_r <= 1'b0;
          end
        end
        ACCESS: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
        RD_WAIT: begin
          if (src_r == SRC_LOCAL) begin
            loc_rdata_r  <= bus.mem_rdata;
            loc_rvalid_r <= 1'b1;
          end else begin
            loc_rvalid_r <= 1'b0;
          end
        end
        default: mem_en_r <= 1'b0;
      endcase

      // SPI read data is only delivered while the master still holds its frame.
      if ((state_r == RD_WAIT) && (src_r == SRC_SPI) && bus.rx_valid) begin
        tx_data_r  <= bus.mem_rdata;
        tx_valid_r <= 1'b1;
      end else if (!bus.rx_valid) begin
        tx_valid_r <= 1'b0;
      end else begin
        tx_valid_r <= tx_valid_r;
      end
    end
  end

  assign bus.mem_en     = mem_en_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.tx_valid   = tx_valid_r;
  assign bus.loc_gnt    = loc_gnt_r;
  assign bus.loc_rvalid = loc_rvalid_r;
  assign bus.loc_rdata  = loc_rdata_r;
  assign bus.cmd_drop   = cmd_drop_r;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Sequencer and arbiter between the SPI slave's 10-bit command stream and one single-port synchronous RAM. Decodes SPI frames into address-load, write and read operations. Shares the RAM port round-robin with a local requester, and returns read data to the SPI slave over tx_data/tx_valid. Sits between the SPI slave and the RAM; owns every RAM control signal.

Parameters:
ADDR_SIZE, 8, RAM address width; legal 1..8; address taken from payload[ADDR_SIZE-1:0]
MEM_DEPTH, 256, RAM depth; must equal 2**ADDR_SIZE

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  10  SPI frame; [9:8] command, [7:0] payload
rx_valid  in  1  SPI frame valid; level, held high until frame ends
tx_data  out  8  read data to SPI slave
tx_valid  out  1  tx_data valid; level
loc_req  in  1  local access request; held until loc_gnt
loc_we  in  1  local write(1)/read(0)
loc_addr  in  ADDR_SIZE  local address
loc_wdata  in  8  local write data
loc_gnt  out  1  one-cycle pulse: local access issued
loc_rvalid  out  1  one-cycle pulse: loc_rdata valid
loc_rdata  out  8  local read data
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_SIZE  RAM address
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid the cycle after the edge sampling mem_en=1, mem_we=0
cmd_drop  out  1  one-cycle pulse: SPI command discarded

Behaviour:
- Reset is asynchronous and active-low on rst_n. All outputs are 0, and wr_addr, rd_addr, spi_pend and rx_valid_q are 0. The FSM goes to IDLE and last_grant goes to LOCAL. Reset mid-operation aborts immediately; pending ops are lost.
- Frame detect: rx_valid_q is rx_valid delayed one cycle. A new command is rx_valid=1 and rx_valid_q=0; exactly one command per rising edge.
- Command decode, applied at the detecting edge:
  - 00: wr_addr <= payload.
  - 10: rd_addr <= payload.
  - 01: spi_pend <= 1, stored write with data = payload.
  - 11: spi_pend <= 1, stored read.
  - Any command arriving while spi_pend=1 is ignored, and cmd_drop pulses for one cycle.
- FSM states: IDLE, ACCESS, RD_WAIT.
  - IDLE, winner exists: load mem_en=1, mem_we, mem_addr, mem_wdata (all registered). Go to ACCESS.
  - IDLE, local winner: loc_gnt pulses in the same cycle as mem_en; loc_addr/loc_we/loc_wdata are sampled at that edge.
  - ACCESS: mem_en <= 0, mem_we <= 0. Read goes to RD_WAIT; write goes to IDLE.
  - RD_WAIT: capture mem_rdata at the exiting edge, then go to IDLE.
- Arbitration, evaluated only in IDLE:
  - One requester pending (spi_pend or loc_req): it wins.
  - Both pending: the one not equal to last_grant wins. last_grant updates at each grant.
  - First tie after reset goes to SPI.
- SPI write: mem_addr = wr_addr. wr_addr increments modulo 2**ADDR_SIZE at the grant edge. spi_pend clears at the grant edge.
- SPI read: mem_addr = rd_addr, post-incremented modulo 2**ADDR_SIZE at the grant edge.
  - At the RD_WAIT exit: tx_data <= mem_rdata. tx_valid <= 1 only if rx_valid is still 1; otherwise the data is discarded and rd_addr keeps its increment.
- Latency, E0 = edge detecting the command:
  - mem_en is high between E1 and E2.
  - Write lands in RAM at E2.
  - tx_valid rises after E3.
  - Local read: loc_rvalid pulses and loc_rdata updates after the edge 2 cycles past the grant edge.
- tx_valid is held until rx_valid is sampled 0, then cleared. tx_data holds its value.
- Throughput: a write occupies 2 cycles (IDLE, ACCESS); a read occupies 3. The FSM may grant again in the first IDLE cycle after returning.
- A simultaneous new SPI command and an SPI grant at the same edge cannot occur, because spi_pend blocks new captures.
- Local requests see no backpressure beyond delayed loc_gnt.

Test Plan:
- Reset, then frames 0x005 and 0x1A7 (addr 0x05, write 0xA7). Required: one mem_en/mem_we cycle with mem_addr=0x05, mem_wdata=0xA7; wr_addr becomes 0x06.
- Frames 0x205, then 0x300 with RAM[5]=0xA7 and rx_valid held. Required: tx_data=0xA7 and tx_valid high exactly 3 cycles after rx_valid rises; tx_valid clears the cycle after rx_valid drops; rd_addr becomes 0x06.
- wr_addr=0xFF, two write frames with 0x11 then 0x22. Required: RAM[0xFF]=0x11, RAM[0x00]=0x22 (wrap).
- SPI write pending and loc_req read of 0x10 raised in the same cycle after reset. Required: SPI granted first, loc_gnt in the next IDLE cycle, loc_rvalid with RAM[0x10] two cycles later. A repeated tie then goes to local.
- Read frame 0x300 with rx_valid dropped 1 cycle after rising. Required: mem read still issued, tx_valid never asserted, rd_addr incremented.
- Second rx_valid rise while spi_pend=1 (local holding the RAM). Required: cmd_drop pulses once; wr_addr/rd_addr unchanged.
- rst_n asserted while the FSM is in ACCESS. Required: mem_en, tx_valid and loc_gnt go low immediately, without waiting for clk.
